pcd8544_rx: RTL and testbench

Display-side receiver for the PCD8544 (Nokia 5110) serial link driven by our SPI master and config FSMs. It oversamples `sce`/`sclk`/`mosi`/`dc` in the FPGA clock domain, assembles bytes and decodes the command set. Data bytes are turned into frame-buffer write strobes at the address the real controller would use. It serves as a bench model for the display path and as the front end of an on-chip mirror of the LCD image.

---
 rtl/pcd8544_pkg.sv | 41 ++++
 rtl/pcd8544_spi_shifter.sv | 83 ++++++++
 rtl/pcd8544_rx.sv | 146 ++++++++++++++
 tb/tb_pcd8544_rx.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pcd8544_pkg.sv
// rtl/pcd8544_pkg.sv - shared constants, opcode masks and address helper for the PCD8544 receiver
package pcd8544_pkg;

    localparam int COLS     = 84;
    localparam int ROWS     = 6;
    localparam int FB_DEPTH = 504;
    localparam int ADDR_W   = $clog2(FB_DEPTH);

    // Opcode recognition: a byte matches when (byte & MASK) == VAL
    localparam logic [7:0] FSET_MASK = 8'hF8;
    localparam logic [7:0] FSET_VAL  = 8'h20;
    localparam logic [7:0] DCTL_MASK = 8'hFA;
    localparam logic [7:0] DCTL_VAL  = 8'h08;
    localparam logic [7:0] SETY_MASK = 8'hF8;
    localparam logic [7:0] SETY_VAL  = 8'h40;
    localparam logic [7:0] SETX_MASK = 8'h80;
    localparam logic [7:0] SETX_VAL  = 8'h80;
    localparam logic [7:0] TC_MASK   = 8'hFC;
    localparam logic [7:0] TC_VAL    = 8'h04;
    localparam logic [7:0] BIAS_MASK = 8'hF8;
    localparam logic [7:0] BIAS_VAL  = 8'h10;
    localparam logic [7:0] VOP_MASK  = 8'h80;
    localparam logic [7:0] VOP_VAL   = 8'h80;

    // disp_mode = {D,E}
    localparam logic [1:0] DISP_BLANK   = 2'b00;
    localparam logic [1:0] DISP_NORMAL  = 2'b10;
    localparam logic [1:0] DISP_ALL_ON  = 2'b01;
    localparam logic [1:0] DISP_INVERSE = 2'b11;

    function automatic logic op_match(input logic [7:0] b, input logic [7:0] mask,
                                      input logic [7:0] val);
        return (b & mask) == val;
    endfunction

    // y*84 + x built from shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [2:0] y, input logic [6:0] x);
        return {y, 6'b0} + {2'b0, y, 4'b0} + {4'b0, y, 2'b0} + {2'b0, x};
    endfunction

endpackage

// File: rtl/pcd8544_spi_shifter.sv
// rtl/pcd8544_spi_shifter.sv - pad synchronisers, sclk edge detect, byte shifter and bit counter
module pcd8544_spi_shifter
    import pcd8544_pkg::*;
(
    input  logic       clock,
    input  logic       Reset,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       sce,
    input  logic       dc,
    input  logic       rst,
    output logic       byte_done,
    output logic [7:0] byte_val,
    output logic       byte_dc,
    output logic       rst_run
);

    // Pad order inside the synchroniser vectors: {rst, dc, sce, mosi, sclk}
    localparam logic [4:0] SYNC_INIT = 5'b00100;

    logic [4:0] sync1;
    logic [4:0] sync2;
    logic       sclk_d;
    logic       sce_d;
    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    logic sclk_s, mosi_s, sce_s, dc_s, rst_s;
    logic sclk_rise, shift_en;

    assign {rst_s, dc_s, sce_s, mosi_s, sclk_s} = sync2;
    assign rst_run   = rst_s;
    assign sclk_rise = sclk_s & ~sclk_d;
    // Gating on the previous sce lets a byte whose 8th edge coincides with sce rising still complete
    assign shift_en  = sclk_rise & ~sce_d;

    // Two-flop synchronisers for every pad, then the edge-detect history
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            sync1  <= SYNC_INIT;
            sync2  <= SYNC_INIT;
            sclk_d <= 1'b0;
            sce_d  <= 1'b1;
        end else begin
            sync1  <= {rst, dc, sce, mosi, sclk};
            sync2  <= sync1;
            sclk_d <= sclk_s;
            sce_d  <= sce_s;
        end
    end

    // Shift MSB-first on each qualified sclk rise; flag the byte on the 8th bit
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            byte_val  <= '0;
            byte_dc   <= 1'b0;
        end else if (!rst_s) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            byte_val  <= '0;
            byte_dc   <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (shift_en) begin
                shreg   <= {shreg[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_done <= 1'b1;
                    byte_val  <= {shreg[6:0], mosi_s};
                    byte_dc   <= dc_s;
                end
            end
            if (sce_s) begin
                bit_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pcd8544_rx.sv
// rtl/pcd8544_rx.sv - PCD8544 receiver top: command decode and frame-buffer address counters (option: PCD8544_RX_EXT_CMD_EN)
module pcd8544_rx
    import pcd8544_pkg::*;
(
    input  logic              clock,
    input  logic              Reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              sce,
    input  logic              dc,
    input  logic              rst,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_byte,
    output logic              power_down,
    output logic [1:0]        disp_mode,
    output logic [6:0]        vop,
    output logic [2:0]        bias,
    output logic [1:0]        tc
);

    localparam logic [6:0] LAST_X = 7'(COLS - 1);
    localparam logic [2:0] LAST_Y = 3'(ROWS - 1);

    logic       byte_done;
    logic [7:0] byte_val;
    logic       byte_dc;
    logic       rst_run;

    logic [6:0] x;
    logic [2:0] y;
    logic       h;
    logic       v;

    pcd8544_spi_shifter u_shifter (
        .clock     (clock),
        .Reset     (Reset),
        .sclk      (sclk),
        .mosi      (mosi),
        .sce       (sce),
        .dc        (dc),
        .rst       (rst),
        .byte_done (byte_done),
        .byte_val  (byte_val),
        .byte_dc   (byte_dc),
        .rst_run   (rst_run)
    );

    // Basic-set decode, data strobes and X/Y auto-increment
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            power_down <= 1'b1;
            disp_mode  <= DISP_BLANK;
            x          <= '0;
            y          <= '0;
            h          <= 1'b0;
            v          <= 1'b0;
        end else if (!rst_run) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            power_down <= 1'b1;
            disp_mode  <= DISP_BLANK;
            x          <= '0;
            y          <= '0;
            h          <= 1'b0;
            v          <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            cmd_valid <= 1'b0;
            if (byte_done && byte_dc) begin
                wr_en   <= 1'b1;
                wr_addr <= fb_addr(y, x);
                wr_data <= byte_val;
                if (!v) begin
                    if (x == LAST_X) begin
                        x <= '0;
                        y <= (y == LAST_Y) ? 3'd0 : y + 3'd1;
                    end else begin
                        x <= x + 7'd1;
                    end
                end else begin
                    if (y == LAST_Y) begin
                        y <= '0;
                        x <= (x == LAST_X) ? 7'd0 : x + 7'd1;
                    end else begin
                        y <= y + 3'd1;
                    end
                end
            end else if (byte_done) begin
                cmd_valid <= 1'b1;
                cmd_byte  <= byte_val;
                if (op_match(byte_val, FSET_MASK, FSET_VAL)) begin
                    power_down <= byte_val[2];
                    v          <= byte_val[1];
                    h          <= byte_val[0];
                end else if (!h) begin
                    if (op_match(byte_val, DCTL_MASK, DCTL_VAL)) begin
                        disp_mode <= {byte_val[2], byte_val[0]};
                    end else if (op_match(byte_val, SETY_MASK, SETY_VAL)) begin
                        if (byte_val[2:0] <= LAST_Y) y <= byte_val[2:0];
                    end else if (op_match(byte_val, SETX_MASK, SETX_VAL)) begin
                        if (byte_val[6:0] <= LAST_X) x <= byte_val[6:0];
                    end
                end
            end
        end
    end

`ifdef PCD8544_RX_EXT_CMD_EN
    // Extended-set registers, only written while H=1
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            vop  <= '0;
            bias <= '0;
            tc   <= '0;
        end else if (!rst_run) begin
            vop  <= '0;
            bias <= '0;
            tc   <= '0;
        end else if (byte_done && !byte_dc && h) begin
            if (op_match(byte_val, TC_MASK, TC_VAL)) begin
                tc <= byte_val[1:0];
            end else if (op_match(byte_val, BIAS_MASK, BIAS_VAL)) begin
                bias <= byte_val[2:0];
            end else if (op_match(byte_val, VOP_MASK, VOP_VAL)) begin
                vop <= byte_val[6:0];
            end
        end
    end
`else
    assign vop  = '0;
    assign bias = '0;
    assign tc   = '0;
`endif

endmodule

// File: tb/tb_pcd8544_rx.sv
// tb/tb_pcd8544_rx.sv - scoreboard bench for pcd8544_rx
module tb_pcd8544_rx;

    logic       clock = 1'b0;
    logic       Reset;
    logic       sclk, mosi, sce, dc, rst;
    logic       wr_en, cmd_valid, power_down;
    logic [8:0] wr_addr;
    logic [7:0] wr_data, cmd_byte;
    logic [1:0] disp_mode, tc;
    logic [6:0] vop;
    logic [2:0] bias;

`ifdef PCD8544_RX_EXT_CMD_EN
    localparam logic [6:0] EXP_VOP = 7'h10;
`else
    localparam logic [6:0] EXP_VOP = 7'h00;
`endif

    typedef struct {
        logic        is_wr;
        logic [16:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_rise = 0;
    int   mx = 0, my = 0;
    bit   mv = 0, mh = 0;

    pcd8544_rx dut (
        .clock      (clock),
        .Reset      (Reset),
        .sclk       (sclk),
        .mosi       (mosi),
        .sce        (sce),
        .dc         (dc),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .power_down (power_down),
        .disp_mode  (disp_mode),
        .vop        (vop),
        .bias       (bias),
        .tc         (tc)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_cmd_valid"}, cmd_valid, 0);
        chk({tag, "_cmd_byte"}, cmd_byte, 0);
        chk({tag, "_power_down"}, power_down, 1);
        chk({tag, "_disp_mode"}, disp_mode, 0);
        chk({tag, "_ext"}, {vop, bias, tc}, 0);
    endtask

    // Reference model: queue the expected strobe and update the model address state
    task automatic push_byte(input logic [7:0] b, input logic d);
        exp_t e;
        if (d) begin
            e.is_wr = 1'b1;
            e.val   = {9'(my * 84 + mx), b};
            if (!mv) begin
                mx = mx + 1;
                if (mx == 84) begin mx = 0; my = (my + 1) % 6; end
            end else begin
                my = my + 1;
                if (my == 6) begin my = 0; mx = (mx + 1) % 84; end
            end
        end else begin
            e.is_wr = 1'b0;
            e.val   = {9'd0, b};
            if ((b & 8'hF8) == 8'h20) begin
                mv = b[1];
                mh = b[0];
            end else if (!mh) begin
                if ((b & 8'hF8) == 8'h40 && b[2:0] < 6) my = b[2:0];
                else if (b[7] && b[6:0] < 84) mx = b[6:0];
            end
        end
        sb.push_back(e);
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mv = 0; mh = 0;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic d);
        logic [7:0] bv;
        bv = b;
        sce = 1'b0;
        repeat (2) @(posedge clock);
        for (int i = 0; i < n; i++) begin
            #1 mosi = bv[7-i];
            dc = d;
            repeat (4) @(posedge clock);
            #1 sclk = 1'b1;
            last_rise = cyc;
            repeat (4) @(posedge clock);
            #1 sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d, input bit expect_out);
        if (expect_out) push_byte(b, d);
        send_bits(b, 8, d);
        repeat (4) @(posedge clock);
        #1 sce = 1'b1;
        repeat (4) @(posedge clock);
    endtask

    // Scoreboard consumer: every strobe must match the head of the queue with fixed latency
    always @(negedge clock) begin
        if (Reset && (wr_en || cmd_valid)) begin
            if (sb.size() == 0) begin
                chk("unexpected_strobe", {30'b0, wr_en, cmd_valid}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe_kind", {wr_en, cmd_valid}, mon_e.is_wr ? 2'b10 : 2'b01);
                if (mon_e.is_wr) chk("wr_addr_data", {wr_addr, wr_data}, mon_e.val);
                else chk("cmd_byte", cmd_byte, mon_e.val[7:0]);
                chk("latency", cyc - last_rise, 4);
            end
        end
    end

    initial begin
        Reset = 1'b0; sce = 1'b1; sclk = 1'b0; mosi = 1'b0; dc = 1'b0; rst = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk_reset_state("por");
        Reset = 1'b1;
        repeat (4) @(posedge clock);

        // Init sequence
        send_byte(8'h21, 0, 1);
        send_byte(8'h90, 0, 1);
        send_byte(8'h20, 0, 1);
        send_byte(8'h0C, 0, 1);
        @(negedge clock);
        chk("init_vop", vop, EXP_VOP);
        chk("init_pd", power_down, 0);
        chk("init_disp", disp_mode, 2'b10);

        // Addressed writes
        send_byte(8'h8A, 0, 1);
        send_byte(8'h42, 0, 1);
        send_byte(8'hAA, 1, 1);
        send_byte(8'h55, 1, 1);

        // Horizontal wrap and out-of-range X
        send_byte(8'hD3, 0, 1);
        send_byte(8'h45, 0, 1);
        send_byte(8'h11, 1, 1);
        send_byte(8'h22, 1, 1);
        send_byte(8'hFF, 0, 1);
        send_byte(8'h33, 1, 1);

        // Vertical addressing
        send_byte(8'h22, 0, 1);
        send_byte(8'h80, 0, 1);
        send_byte(8'h45, 0, 1);
        send_byte(8'h44, 1, 1);
        send_byte(8'h56, 1, 1);

        // Partial byte aborted by sce
        send_byte(8'h0D, 0, 1);
        @(negedge clock);
        chk("inverse_disp", disp_mode, 2'b11);
        send_bits(8'hA5, 5, 0);
        repeat (4) @(posedge clock);
        #1 sce = 1'b1;
        repeat (6) @(posedge clock);
        send_byte(8'h0C, 0, 1);
        @(negedge clock);
        chk("abort_cmd_byte", cmd_byte, 8'h0C);
        chk("abort_disp", disp_mode, 2'b10);

        // Asynchronous Reset mid-byte, mid-pulse
        send_bits(8'hF0, 3, 0);
        repeat (4) @(posedge clock);
        #1 sclk = 1'b1;
        #3 Reset = 1'b0;
        #1 chk_reset_state("async");
        repeat (2) @(posedge clock);
        #1 sclk = 1'b0;
        sce = 1'b1;
        repeat (2) @(posedge clock);
        #1 Reset = 1'b1;
        model_reset();
        repeat (4) @(posedge clock);
        send_byte(8'h0C, 0, 1);
        @(negedge clock);
        chk("post_reset_disp", disp_mode, 2'b10);
        chk("post_reset_pd", power_down, 1);
        send_byte(8'h66, 1, 1);

        // Synchronous LCD rst
        send_byte(8'h20, 0, 1);
        send_byte(8'h85, 0, 1);
        send_byte(8'h99, 1, 1);
        #1 rst = 1'b0;
        repeat (6) @(posedge clock);
        @(negedge clock);
        chk_reset_state("lcd_rst");
        send_byte(8'h0D, 0, 0);
        #1 rst = 1'b1;
        model_reset();
        repeat (4) @(posedge clock);
        send_byte(8'h77, 1, 1);
        @(negedge clock);
        chk("rst_ignored_byte_disp", disp_mode, 2'b00);

        repeat (10) @(posedge clock);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
